vbs_capture: RTL and testbench
==============================

VBS_CAPTURE -- requirements
Module: vbs_capture

Interface
REQ-001 Parameter H_START, default 96: clocks from line-start sync falling edge to first sampled pixel.
REQ-002 Parameter ACTIVE_W, default 320: pixels sampled per active line; must be a multiple of 8.
REQ-003 Parameter V_START, default 31: line index of the first active line, counted from line 0 after vertical sync.
REQ-004 Parameter ACTIVE_H, default 192: active lines per frame.
REQ-005 Parameter VSYNC_MIN, default 256: minimum clocks a level must persist to be treated as a broad (vertical) pulse.
REQ-006 Parameter LINE_MIN, default 448: earliest hPos at which a falling edge is accepted as a line start.
REQ-007 Parameter LINE_TIMEOUT, default 1023: hPos value at which lock is declared lost.
REQ-008 Port clk, input, 1 bit: single clock, 8 MHz, the same rate as the video generator.
REQ-009 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port sync, input, 1 bit: composite sync; low means sync pulse; asynchronous to clk.
REQ-011 Port pixel, input, 1 bit: video level; 1 means set pixel; asynchronous to clk.
REQ-012 Port wr_en, output, 1 bit: one-cycle video-RAM write strobe.
REQ-013 Port wr_addr, output, 13 bits: video-RAM byte address.
REQ-014 Port wr_data, output, 8 bits: packed pixels; the first-sampled pixel is in bit 7.
REQ-015 Port locked, output, 1 bit: high while line and frame timing are tracked.
REQ-016 Port frame_start, output, 1 bit: one-cycle pulse at line 0 of each locked frame.

Function
REQ-017 sync and pixel SHALL each pass through an identical 2-flop synchronizer; all timing below refers to the synchronized signals.
REQ-018 hPos (10-bit) SHALL reset to 0 on every accepted line-start edge and otherwise increment each clock, saturating at LINE_TIMEOUT.
REQ-019 FSM states: HUNT, VSYNC, LOCKED. The FSM resets to HUNT.
REQ-020 HUNT -> VSYNC when sync has been low continuously for VSYNC_MIN clocks.
REQ-021 In VSYNC, short pulses SHALL be ignored. VSYNC -> LOCKED on the first falling edge that follows a high level lasting at least VSYNC_MIN clocks.
- That edge is line 0: hPos=0, line=0, frame_start=1 for that cycle.
REQ-022 In LOCKED, a falling edge with hPos >= LINE_MIN SHALL start a new line (line+1, hPos=0). Falling edges with hPos < LINE_MIN SHALL be ignored.
REQ-023 In LOCKED, a low level of VSYNC_MIN clocks -> VSYNC, and the current frame's writes stop.
REQ-024 In LOCKED, hPos reaching LINE_TIMEOUT -> HUNT with locked=0.
REQ-025 A line is active when V_START <= line < V_START+ACTIVE_H.
- Pixels are sampled at hPos = H_START+k, for k = 0 .. ACTIVE_W-1.
REQ-026 After every 8th sample, SHALL assert wr_en for exactly 1 cycle, on the clock after that sample.
- wr_data holds the 8 packed samples.
- wr_addr = (line-V_START)*(ACTIVE_W/8) + byte index.
- Addresses are linear, 0..7679 at the defaults.
REQ-027 wr_addr and wr_data SHALL hold their values between strobes. No write occurs outside active lines or when not LOCKED.
REQ-028 locked SHALL be 1 exactly while the FSM is in LOCKED.
REQ-029 Leaving LOCKED mid-line SHALL discard any partially packed byte.
REQ-030 Lines beyond V_START+ACTIVE_H SHALL produce no writes until the next vertical sync.

Reset
REQ-031 While reset_n is low, SHALL force FSM=HUNT and clear all counters, synchronizers and the shift register.
- Outputs: wr_en=0, wr_addr=0, wr_data=0, locked=0, frame_start=0.
REQ-032 Reset deassertion mid-frame SHALL require a full vertical sync before the first write.

Structure
REQ-033 The FSM state encoding and the default timing constants SHALL live in the shared package vbs_pkg.
REQ-034 Pulse-width classification of sync (long-low, long-high, falling-edge detection) SHALL be a sub-module, vbs_sync_sep.

Verification
REQ-035 Bench driven by the existing generator with a capture RAM model:
- after 2 frames, locked=1;
- the RAM image equals the generator's pattern on all 7680 bytes.
REQ-036 Sync held high with no edges:
- locked stays 0 and wr_en never asserts;
- a 300-clock low pulse then moves the FSM to VSYNC.
REQ-037 Glitch low pulse of 3 clocks at hPos=200 in LOCKED:
- the line count is unchanged;
- writes continue at the correct addresses.
REQ-038 Sync stuck low mid-frame for 1100 clocks: locked goes 0 and no writes occur until the next valid vertical sync.
REQ-039 Pixel pattern 10110001 at the first 8 samples of line V_START: wr_addr=0, wr_data=0xB1, wr_en for 1 cycle.
REQ-040 reset_n asserted at line 100:
- all outputs go to 0 immediately;
- after release, the first frame_start follows the next vertical sync.

Source files
------------

// File: rtl/vbs_pkg.sv
// Shared constants for the composite-video capture block: FSM encoding, bus widths,
// default timing and the write-beat record.
package vbs_pkg;

   localparam int HPOS_W = 10;
   localparam int LINE_W = 10;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VSYNC  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam int H_START_DEF      = 96;
   localparam int ACTIVE_W_DEF     = 320;
   localparam int V_START_DEF      = 31;
   localparam int ACTIVE_H_DEF     = 192;
   localparam int VSYNC_MIN_DEF    = 256;
   localparam int LINE_MIN_DEF     = 448;
   localparam int LINE_TIMEOUT_DEF = 1023;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } vbs_wr_t;

   // hPos and line counters share one width and both stop at a ceiling
   function automatic logic [HPOS_W-1:0] cnt_sat_inc(input logic [HPOS_W-1:0] v,
                                                     input logic [HPOS_W-1:0] lim);
      logic [HPOS_W-1:0] r;
      if (v >= lim) begin
         r = lim;
      end else begin
         r = v + HPOS_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/vbs_capture_if.sv
// Video-RAM write port: a one-cycle strobe with address and packed pixel byte.
interface vbs_capture_if;
   import vbs_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/vbs_sync_sep.sv
// Sync separator: measures how long the synchronized sync level has persisted and
// flags falling edges, long low levels and falling edges that end a long high level.
module vbs_sync_sep
   import vbs_pkg::*;
#(
   parameter int VSYNC_MIN = VSYNC_MIN_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_s,
   output logic fall_s,
   output logic long_low_s,
   output logic long_high_fall_s
);

   localparam int              RUN_W   = $clog2(VSYNC_MIN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VSYNC_MIN);

   logic             level_r;
   logic [RUN_W-1:0] run_r;

   // Run-length of the current sync level, saturating once it counts as broad
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_r <= 1'b0;
         run_r   <= '0;
      end else begin
         level_r <= sync_s;
         if (sync_s != level_r) begin
            run_r <= RUN_W'(1);
         end else if (run_r != RUN_MAX) begin
            run_r <= run_r + RUN_W'(1);
         end else begin
            run_r <= run_r;
         end
      end
   end

   assign fall_s           = level_r & ~sync_s;
   assign long_low_s       = ~level_r & ~sync_s & (run_r == RUN_MAX);
   assign long_high_fall_s = fall_s & (run_r == RUN_MAX);

endmodule

// File: rtl/vbs_capture.sv
// Composite-video capture: tracks line/frame timing from sync and streams the packed
// pixels of every active line into video RAM, one byte per strobe.
module vbs_capture
   import vbs_pkg::*;
#(
   parameter int H_START      = H_START_DEF,
   parameter int ACTIVE_W     = ACTIVE_W_DEF,
   parameter int V_START      = V_START_DEF,
   parameter int ACTIVE_H     = ACTIVE_H_DEF,
   parameter int VSYNC_MIN    = VSYNC_MIN_DEF,
   parameter int LINE_MIN     = LINE_MIN_DEF,
   parameter int LINE_TIMEOUT = LINE_TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          sync,
   input  logic          pixel,
   vbs_capture_if.master wr,
   output logic          locked,
   output logic          frame_start
);

   localparam int                BPL     = ACTIVE_W / 8;
   localparam logic [HPOS_W-1:0] H_FIRST = HPOS_W'(H_START);
   localparam logic [HPOS_W-1:0] H_LAST  = HPOS_W'(H_START + ACTIVE_W - 1);
   localparam logic [HPOS_W-1:0] H_MIN   = HPOS_W'(LINE_MIN);
   localparam logic [HPOS_W-1:0] H_TMO   = HPOS_W'(LINE_TIMEOUT);
   localparam logic [LINE_W-1:0] V_FIRST = LINE_W'(V_START);
   localparam logic [LINE_W-1:0] V_END   = LINE_W'(V_START + ACTIVE_H);
   localparam logic [LINE_W-1:0] L_MAX   = {LINE_W{1'b1}};

   logic [1:0]        sync_ff_r;
   logic [1:0]        pixel_ff_r;
   logic              sync_s;
   logic              pixel_s;
   logic              fall_s;
   logic              long_low_s;
   logic              long_high_fall_s;

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [HPOS_W-1:0] hpos_r;
   logic [LINE_W-1:0] line_r;
   logic [6:0]        shift_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              locked_r;
   logic              frame_start_r;

   logic              line_start_s;
   logic              frame_sync_s;
   logic              in_window_s;
   logic              line_active_s;
   logic              sample_s;
   logic              store_s;
   logic [HPOS_W-1:0] samp_idx_s;
   logic [ADDR_W-1:0] addr_s;

   // Two-flop synchronizers for the asynchronous video inputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff_r  <= 2'b00;
         pixel_ff_r <= 2'b00;
      end else begin
         sync_ff_r  <= {sync_ff_r[0], sync};
         pixel_ff_r <= {pixel_ff_r[0], pixel};
      end
   end

   assign sync_s  = sync_ff_r[1];
   assign pixel_s = pixel_ff_r[1];

   vbs_sync_sep #(
      .VSYNC_MIN (VSYNC_MIN)
   ) u_sync_sep (
      .clk              (clk),
      .reset_n          (reset_n),
      .sync_s           (sync_s),
      .fall_s           (fall_s),
      .long_low_s       (long_low_s),
      .long_high_fall_s (long_high_fall_s)
   );

   // Lock FSM; a broad low always wins over line timing, timeout beats a late edge
   always_comb begin
      state_nxt_s  = state_r;
      line_start_s = 1'b0;
      case (state_r)
         ST_HUNT: begin
            if (long_low_s) begin
               state_nxt_s = ST_VSYNC;
            end else begin
               state_nxt_s = ST_HUNT;
            end
         end
         ST_VSYNC: begin
            if (long_high_fall_s) begin
               state_nxt_s  = ST_LOCKED;
               line_start_s = 1'b1;
            end else begin
               state_nxt_s = ST_VSYNC;
            end
         end
         ST_LOCKED: begin
            if (long_low_s) begin
               state_nxt_s = ST_VSYNC;
            end else if (hpos_r == H_TMO) begin
               state_nxt_s = ST_HUNT;
            end else if (fall_s && (hpos_r >= H_MIN)) begin
               state_nxt_s  = ST_LOCKED;
               line_start_s = 1'b1;
            end else begin
               state_nxt_s = ST_LOCKED;
            end
         end
         default: begin
            state_nxt_s = ST_HUNT;
         end
      endcase
   end

   assign frame_sync_s  = (state_r == ST_VSYNC) && long_high_fall_s;
   assign samp_idx_s    = hpos_r - H_FIRST;
   assign in_window_s   = (hpos_r >= H_FIRST) && (hpos_r <= H_LAST);
   assign line_active_s = (line_r >= V_FIRST) && (line_r < V_END);
   // Samples are only taken while lock persists into the next cycle, so a lost frame writes nothing
   assign sample_s      = (state_r == ST_LOCKED) && (state_nxt_s == ST_LOCKED) &&
                          line_active_s && in_window_s;
   assign store_s       = sample_s && (samp_idx_s[2:0] == 3'b111);
   assign addr_s        = ADDR_W'(line_r - V_FIRST) * ADDR_W'(BPL) +
                          ADDR_W'(samp_idx_s[HPOS_W-1:3]);

   // Line timing: hPos, line index and lock state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_HUNT;
         hpos_r  <= '0;
         line_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (line_start_s) begin
            hpos_r <= '0;
         end else begin
            hpos_r <= cnt_sat_inc(hpos_r, H_TMO);
         end
         if (frame_sync_s) begin
            line_r <= '0;
         end else if (line_start_s) begin
            line_r <= cnt_sat_inc(line_r, L_MAX);
         end else begin
            line_r <= line_r;
         end
      end
   end

   // Pixel packing and registered write port; a partial byte is dropped whenever lock ends
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_r       <= '0;
         wr_en_r       <= 1'b0;
         wr_addr_r     <= '0;
         wr_data_r     <= '0;
         locked_r      <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         if (state_nxt_s != ST_LOCKED) begin
            shift_r <= '0;
         end else if (sample_s) begin
            shift_r <= {shift_r[5:0], pixel_s};
         end else begin
            shift_r <= shift_r;
         end
         wr_en_r <= store_s;
         if (store_s) begin
            wr_addr_r <= addr_s;
            wr_data_r <= {shift_r, pixel_s};
         end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
         end
         locked_r      <= (state_nxt_s == ST_LOCKED);
         frame_start_r <= frame_sync_s;
      end
   end

   assign wr.wr_en    = wr_en_r;
   assign wr.wr_addr  = wr_addr_r;
   assign wr.wr_data  = wr_data_r;
   assign locked      = locked_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vbs_capture.sv
// Bench for vbs_capture: a scaled-down composite-sync generator drives the capture block,
// expected RAM writes go to a scoreboard queue and a RAM model collects the image.
module tb_vbs_capture;

   localparam int H_START      = 16;
   localparam int ACTIVE_W     = 32;
   localparam int V_START      = 3;
   localparam int ACTIVE_H     = 6;
   localparam int VSYNC_MIN    = 64;
   localparam int LINE_MIN     = 96;
   localparam int LINE_TIMEOUT = 255;
   localparam int BPL          = ACTIVE_W / 8;
   localparam int LINE_CLKS    = 128;
   localparam int SYNC_W       = 8;
   localparam int BROAD_LOW    = 120;
   localparam int N_LINES      = 12;

   logic clk;
   logic reset_n;
   logic sync;
   logic pixel;
   logic locked;
   logic frame_start;

   vbs_capture_if wr_if ();

   vbs_capture #(
      .H_START      (H_START),
      .ACTIVE_W     (ACTIVE_W),
      .V_START      (V_START),
      .ACTIVE_H     (ACTIVE_H),
      .VSYNC_MIN    (VSYNC_MIN),
      .LINE_MIN     (LINE_MIN),
      .LINE_TIMEOUT (LINE_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sync        (sync),
      .pixel       (pixel),
      .wr          (wr_if),
      .locked      (locked),
      .frame_start (frame_start)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int fs_cnt  = 0;
   logic wr_en_q = 1'b0;
   vbs_pkg::vbs_wr_t exp_q[$];
   logic [7:0] img [ACTIVE_H][BPL];
   logic [7:0] ram [0:8191];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every strobe must match the oldest expected write
   always @(negedge clk) begin
      vbs_pkg::vbs_wr_t e;
      if (frame_start === 1'b1) fs_cnt++;
      if (wr_if.wr_en === 1'b1) begin
         n_tests++;
         if (wr_en_q === 1'b1) begin
            n_fail++;
            $display("FAIL wr_en_width strobe high on consecutive cycles addr=%0d", wr_if.wr_addr);
         end
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write got addr=%0d data=%h, expected no write",
                     wr_if.wr_addr, wr_if.wr_data);
         end else begin
            e = exp_q.pop_front();
            if (wr_if.wr_addr !== e.addr || wr_if.wr_data !== e.data) begin
               n_fail++;
               $display("FAIL write got addr=%0d data=%h, expected addr=%0d data=%h",
                        wr_if.wr_addr, wr_if.wr_data, e.addr, e.data);
            end
         end
         ram[wr_if.wr_addr] = wr_if.wr_data;
      end
      wr_en_q = wr_if.wr_en;
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      sync    = 1'b1;
      pixel   = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic idle(input int n, input logic s);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sync  = s;
         pixel = 1'($urandom & 32'd1);
      end
   endtask

   // One line whose sync falls at cycle 0; cap is the line index the capture assigns it
   task automatic gen_line(input int cap, input bit exp_wr, input int mode);
      vbs_pkg::vbs_wr_t e;
      logic [7:0] b;
      int k;
      for (int c = 0; c < LINE_CLKS; c++) begin
         @(negedge clk);
         sync = (c < SYNC_W) ? 1'b0 : 1'b1;
         if (mode == 1 && c >= 60 && c < 63) sync = 1'b0;
         if (mode == 2 && c >= 60) sync = 1'b0;
         pixel = 1'($urandom & 32'd1);
         if (c >= H_START + 1 && c <= H_START + ACTIVE_W) begin
            k = c - H_START - 1;
            if (cap >= V_START && cap < V_START + ACTIVE_H) begin
               b     = img[cap - V_START][k / 8];
               pixel = b[7 - (k % 8)];
               if (exp_wr && (k % 8) == 7) begin
                  e.addr = 13'((cap - V_START) * BPL + k / 8);
                  e.data = b;
                  exp_q.push_back(e);
               end
            end
         end
      end
   endtask

   task automatic gen_broad();
      for (int l = 0; l < 2; l++) begin
         for (int c = 0; c < LINE_CLKS; c++) begin
            @(negedge clk);
            sync  = (c < BROAD_LOW) ? 1'b0 : 1'b1;
            pixel = 1'($urandom & 32'd1);
         end
      end
   endtask

   task automatic gen_frame(input bit exp_wr, input int glitch_cap);
      gen_broad();
      for (int n = 0; n < N_LINES; n++) begin
         gen_line(n - 1, exp_wr && (n > 0), (n - 1 == glitch_cap) ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      sync    = 1'b1;
      pixel   = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, locked, frame_start} !== 24'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got en=%b addr=%0d data=%h lk=%b fs=%b, expected all 0",
                  wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, locked, frame_start);
      end
      reset_n = 1'b1;
      idle(20, 1'b1);
      n_tests++;
      if (locked !== 1'b0 || frame_start !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset got lk=%b fs=%b, expected 0 0", locked, frame_start);
      end
   endtask

   task automatic test_no_edges();
      int fs0;
      bit saw_lock;
      do_reset();
      saw_lock = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         sync  = 1'b1;
         pixel = 1'($urandom & 32'd1);
         if (locked !== 1'b0) saw_lock = 1'b1;
      end
      n_tests++;
      if (saw_lock !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_high got locked=1 during idle, expected 0");
      end
      idle(300, 1'b0);
      idle(120, 1'b1);
      fs0 = fs_cnt;
      idle(SYNC_W, 1'b0);
      idle(SYNC_W, 1'b1);
      n_tests++;
      if (fs_cnt - fs0 !== 1 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL vsync_from_low got fs=%0d lk=%b, expected fs=1 lk=1", fs_cnt - fs0, locked);
      end
   endtask

   task automatic test_frames();
      int fs0;
      do_reset();
      for (int i = 0; i < ACTIVE_H; i++) begin
         for (int j = 0; j < BPL; j++) img[i][j] = 8'($urandom);
      end
      img[0][0] = 8'hB1;
      for (int a = 0; a < ACTIVE_H * BPL; a++) ram[a] = 8'h00;
      fs0 = fs_cnt;
      gen_frame(1'b1, -1);
      gen_frame(1'b1, -1);
      n_tests++;
      if (locked !== 1'b1 || fs_cnt - fs0 !== 2) begin
         n_fail++;
         $display("FAIL two_frames got lk=%b fs=%0d, expected lk=1 fs=2", locked, fs_cnt - fs0);
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL frames_pending got %0d writes missing, expected 0", exp_q.size());
      end
      for (int a = 0; a < ACTIVE_H * BPL; a++) begin
         n_tests++;
         if (ram[a] !== img[a / BPL][a % BPL]) begin
            n_fail++;
            $display("FAIL ram_image addr=%0d got %h, expected %h", a, ram[a], img[a / BPL][a % BPL]);
         end
      end
      n_tests++;
      if (ram[0] !== 8'hB1) begin
         n_fail++;
         $display("FAIL first_byte got %h, expected b1", ram[0]);
      end
   endtask

   task automatic test_glitch();
      int fs0;
      fs0 = fs_cnt;
      gen_frame(1'b1, V_START + 1);
      n_tests++;
      if (locked !== 1'b1 || fs_cnt - fs0 !== 1 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL glitch got lk=%b fs=%0d pending=%0d, expected lk=1 fs=1 pending=0",
                  locked, fs_cnt - fs0, exp_q.size());
      end
   endtask

   task automatic test_stuck_low();
      int fs0;
      gen_broad();
      for (int n = 0; n < 5; n++) gen_line(n - 1, n > 0, 0);
      gen_line(4, 1'b1, 2);
      idle(1100 - (LINE_CLKS - 60), 1'b0);
      n_tests++;
      if (locked !== 1'b0 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL stuck_low got lk=%b pending=%0d, expected lk=0 pending=0", locked, exp_q.size());
      end
      fs0 = fs_cnt;
      for (int n = 0; n < N_LINES; n++) gen_line(n - 1, n > 0, 0);
      n_tests++;
      if (locked !== 1'b1 || fs_cnt - fs0 !== 1 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL relock got lk=%b fs=%0d pending=%0d, expected lk=1 fs=1 pending=0",
                  locked, fs_cnt - fs0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int fs0;
      gen_broad();
      for (int n = 0; n < 7; n++) gen_line(n - 1, n > 0, 0);
      n_tests++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_lock got lk=%b, expected 1", locked);
      end
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, locked, frame_start} !== 24'd0) begin
         n_fail++;
         $display("FAIL async_reset got en=%b addr=%0d data=%h lk=%b fs=%b, expected all 0",
                  wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, locked, frame_start);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      fs0 = fs_cnt;
      for (int cap = 6; cap < N_LINES - 1; cap++) gen_line(cap, 1'b0, 0);
      n_tests++;
      if (locked !== 1'b0 || fs_cnt - fs0 !== 0) begin
         n_fail++;
         $display("FAIL reset_wait got lk=%b fs=%0d, expected lk=0 fs=0", locked, fs_cnt - fs0);
      end
      gen_frame(1'b1, -1);
      n_tests++;
      if (locked !== 1'b1 || fs_cnt - fs0 !== 1 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_relock got lk=%b fs=%0d pending=%0d, expected lk=1 fs=1 pending=0",
                  locked, fs_cnt - fs0, exp_q.size());
      end
   endtask

   task automatic test_timeout();
      idle(100, 1'b1);
      n_tests++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL before_timeout got lk=%b, expected 1", locked);
      end
      idle(100, 1'b1);
      n_tests++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL after_timeout got lk=%b, expected 0", locked);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      sync    = 1'b1;
      pixel   = 1'b0;
      test_reset();
      test_no_edges();
      test_frames();
      test_glitch();
      test_stuck_low();
      test_reset_mid();
      test_timeout();
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
